// File: rtl/fill_priority_arbiter.sv
// fill_priority_arbiter
// Four-FIFO pixel arbiter that feeds a z-buffer. The arbiter picks the
// fullest non-empty FIFO and breaks fill ties round-robin, starting the
// search just after the previous grant. It pops one pixel from that FIFO
// with a req/ack handshake, then presents the pixel to the z-buffer with a
// send/ready handshake.
// Optional build macro: ARBITER_AGING_EN. When it is defined, each FIFO gets
// a starvation counter. A FIFO that has been passed over 15 times wins the
// next selection regardless of its fill level.
module fill_priority_arbiter #(
   parameter int MEM_LENGTH  = 8,
   parameter int PIXEL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PIXEL_WIDTH-1:0] pix_in_1,
   input  logic [PIXEL_WIDTH-1:0] pix_in_2,
   input  logic [PIXEL_WIDTH-1:0] pix_in_3,
   input  logic [PIXEL_WIDTH-1:0] pix_in_4,
   input  logic [MEM_LENGTH-1:0]  fill_1,
   input  logic [MEM_LENGTH-1:0]  fill_2,
   input  logic [MEM_LENGTH-1:0]  fill_3,
   input  logic [MEM_LENGTH-1:0]  fill_4,
   input  logic                   ack_1,
   input  logic                   ack_2,
   input  logic                   ack_3,
   input  logic                   ack_4,
   input  logic                   rdy_z_buffer,
   output logic                   req_1,
   output logic                   req_2,
   output logic                   req_3,
   output logic                   req_4,
   output logic [PIXEL_WIDTH-1:0] pix_out,
   output logic                   send_z_buffer,
   output logic [1:0]             grant_id
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, SEND} state_t;

   state_t                        state_q, state_d;
   logic [1:0]                    grant_q, grant_d;
   logic [PIXEL_WIDTH-1:0]        pix_q, pix_d;
   // Set when the granted FIFO acked in the same cycle as its request.
   logic                          got_q, got_d;

   logic [3:0][MEM_LENGTH-1:0]    fill;
   logic [3:0][PIXEL_WIDTH-1:0]   pix_in;
   logic [3:0]                    ack;
   logic [3:0]                    nonempty;
   logic [3:0]                    cand;
   logic                          any_req;
   logic                          use_age;
   logic [1:0]                    win;
   logic [1:0]                    idx;
   logic                          win_found;
   logic [MEM_LENGTH-1:0]         best_fill;

   assign fill   = {fill_4, fill_3, fill_2, fill_1};
   assign pix_in = {pix_in_4, pix_in_3, pix_in_2, pix_in_1};
   assign ack    = {ack_4, ack_3, ack_2, ack_1};

   // Flag the FIFOs that currently hold at least one pixel.
   always_comb begin
      nonempty = '0;
      for (int k = 0; k < 4; k++) nonempty[k] = (fill[k] != '0);
   end

   assign any_req = |nonempty;

`ifdef ARBITER_AGING_EN
   logic [3:0][3:0] age_q, age_d;
   logic [3:0]      aged;

   // A FIFO counts as aged when it is non-empty and its counter is saturated.
   always_comb begin
      aged = '0;
      for (int k = 0; k < 4; k++) aged[k] = nonempty[k] && (age_q[k] == 4'd15);
   end

   // When any FIFO is aged, only aged FIFOs compete, and fill is not compared.
   assign use_age = |aged;
   assign cand    = use_age ? aged : nonempty;

   // Update the starvation counters. A counter clears when its FIFO is empty
   // or is granted. It counts up (saturating) when another FIFO is granted.
   always_comb begin
      age_d = age_q;
      for (int k = 0; k < 4; k++) begin
         if (!nonempty[k]) begin
            age_d[k] = '0;
         end else if (state_q == IDLE && any_req) begin
            if (win == 2'(k))           age_d[k] = '0;
            else if (age_q[k] != 4'd15) age_d[k] = age_q[k] + 4'd1;
         end
      end
   end

   // Starvation counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) age_q <= '0;
      else       age_q <= age_d;
   end
`else
   assign use_age = 1'b0;
   assign cand    = nonempty;
`endif

   // Choose the winner. The search starts just after the last grant and
   // wraps, so the first candidate in that order keeps a fill tie.
   always_comb begin
      win_found = 1'b0;
      win       = grant_q;
      best_fill = '0;
      idx       = grant_q;
      for (int i = 1; i <= 4; i++) begin
         idx = grant_q + 2'(i);
         if (cand[idx] && (!win_found || (!use_age && fill[idx] > best_fill))) begin
            win_found = 1'b1;
            win       = idx;
            best_fill = fill[idx];
         end
      end
   end

   // Next-state logic for the handshake sequence and the pixel capture.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      pix_d   = pix_q;
      got_d   = got_q;
      case (state_q)
         IDLE: begin
            got_d = 1'b0;
            if (any_req) begin
               grant_d = win;
               state_d = REQ;
            end
         end
         REQ: begin
            // A zero-wait FIFO may ack in the same cycle as the request.
            if (ack[grant_q]) begin
               pix_d = pix_in[grant_q];
               got_d = 1'b1;
            end
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (got_q) begin
               got_d   = 1'b0;
               state_d = SEND;
            end else if (ack[grant_q]) begin
               pix_d   = pix_in[grant_q];
               state_d = SEND;
            end
         end
         SEND: begin
            if (rdy_z_buffer) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 2'd3;
         pix_q   <= '0;
         got_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         pix_q   <= pix_d;
         got_q   <= got_d;
      end
   end

   assign req_1         = (state_q == REQ) && (grant_q == 2'd0);
   assign req_2         = (state_q == REQ) && (grant_q == 2'd1);
   assign req_3         = (state_q == REQ) && (grant_q == 2'd2);
   assign req_4         = (state_q == REQ) && (grant_q == 2'd3);
   assign send_z_buffer = (state_q == SEND);
   assign pix_out       = pix_q;
   assign grant_id      = grant_q;

endmodule

// File: doc/fill_priority_arbiter.md
FILL_PRIORITY_ARBITER -- requirements
Module: fill_priority_arbiter

Interface
REQ-001 SHALL have parameter MEM_LENGTH, 8, width of each FIFO fill count.
REQ-002 SHALL have parameter PIXEL_WIDTH, 16, pixel word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports pix_in_1..pix_in_4  input  PIXEL_WIDTH each  pixel presented by FIFO k, valid when ack_k=1.
REQ-006 SHALL have ports fill_1..fill_4  input  MEM_LENGTH each  occupancy of FIFO k; 0 = empty.
REQ-007 SHALL have ports ack_1..ack_4  input  1 each  FIFO k pop acknowledge.
REQ-008 SHALL have port rdy_z_buffer  input  1  z-buffer accepts a pixel this cycle.
REQ-009 SHALL have ports req_1..req_4  output  1 each  pop request to FIFO k.
REQ-010 SHALL have port pix_out  output  PIXEL_WIDTH  pixel to z-buffer.
REQ-011 SHALL have port send_z_buffer  output  1  pix_out valid.
REQ-012 SHALL have port grant_id  output  2  index (0..3 = FIFO 1..4) of last/current grant.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT_ACK, SEND.
REQ-014 IDLE: when any fill_k != 0, SHALL select winner, register it in grant_id, go to REQ next cycle; else stay IDLE.
REQ-015 Selection SHALL pick the non-empty FIFO with the largest fill (unsigned compare).
REQ-016 Fill ties SHALL be broken round-robin, searching from grant_id+1 modulo 4.
REQ-017 REQ: SHALL assert req_k of grant_id for exactly one cycle, then go to WAIT_ACK; at most one req_k high at any time.
REQ-018 WAIT_ACK: on ack_k of granted FIFO SHALL register pix_in_k into pix_out and go to SEND; ack from a non-granted FIFO SHALL be ignored.
REQ-019 ack_k arriving in the same cycle as req_k SHALL be accepted (zero-wait FIFO).
REQ-020 SEND: send_z_buffer SHALL be 1 and pix_out held stable until rdy_z_buffer=1; in that cycle the transfer completes and FSM returns to IDLE.
REQ-021 Throughput: SHALL sustain one pixel per 4 cycles minimum (IDLE, REQ, WAIT_ACK with immediate ack, SEND with rdy high).
REQ-022 rdy_z_buffer SHALL be ignored outside SEND; fill changes after selection SHALL not alter the registered grant.

Reset
REQ-023 On reset assertion, regardless of clock, SHALL force state IDLE, req_1..4=0, send_z_buffer=0, pix_out=0, grant_id=3 (so first tie search starts at FIFO 1).
REQ-024 Reset mid-transfer SHALL discard any captured pixel; no send_z_buffer pulse after deassertion until a new grant completes.

Configuration
REQ-025 Macro ARBITER_AGING_EN: when defined, SHALL keep a 4-bit wait counter per FIFO, incremented each grant to another FIFO while that FIFO is non-empty, cleared on own grant or when empty, saturating at 15.
REQ-026 With ARBITER_AGING_EN, any FIFO whose counter equals 15 SHALL win over fill priority; multiple aged FIFOs resolved round-robin per REQ-016.
REQ-027 Without ARBITER_AGING_EN, no counters SHALL exist; selection is REQ-015/016 only.

Verification
REQ-028 Reset then fills {0,0,0,0} for 20 cycles -> req_1..4=0, send_z_buffer=0, grant_id=3 throughout.
REQ-029 fills {3,7,2,0}, immediate acks, pix_in_2=0x1234, rdy=1 -> req_2 pulses one cycle, pix_out=0x1234 with send_z_buffer 4th cycle after IDLE decision.
REQ-030 fills all equal 5, instant acks, rdy=1 -> grants cycle FIFO 1,2,3,4,1 in order.
REQ-031 Single grant, rdy_z_buffer low 6 cycles -> send_z_buffer and pix_out stable 6 cycles, completion on 7th; stray ack_3 during WAIT_ACK for grant 1 ignored.
REQ-032 Reset asserted during WAIT_ACK and during SEND -> outputs return to reset values asynchronously; no spurious send.
REQ-033 ARBITER_AGING_EN: fill_1=1 constant, fill_2=200 constant -> FIFO 1 granted after 15 consecutive FIFO 2 grants; without macro FIFO 1 never granted.
